// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - echoes every received uart byte back to the transmitter through a small FIFO
//
// Purpose:
//   Consumes completed receive bytes from the uart byte interface, buffers them in
//   a 2**DEPTH_LOG2 entry FIFO and replays them to the transmit byte interface one
//   at a time, pacing on the transmitter's idle level.
//
// Optional feature (macro UART_ECHO_CRLF_EN):
//   When defined, every transmitted CR (0x0D) is automatically followed by an LF
//   (0x0A) that is generated locally and never occupies a FIFO slot.
//
// Ports:
//   clk       in   1              byte-interface clock (uart_clk of the uart top)
//   res_n     in   1              asynchronous active-low reset
//   rx_byte   in   8              received byte, valid when rx_rdy rises
//   rx_rdy    in   1              receiver ready level; each 0->1 transition delivers a byte
//   tx_byte   out  8              byte presented to the transmitter
//   stb       out  1              one-cycle strobe, transmitter captures tx_byte
//   tx_rdy    in   1              transmitter idle level (1 = idle, 0 = sending)
//   level     out  DEPTH_LOG2+1   current FIFO occupancy
//   overflow  out  1              sticky, a byte was dropped on a full FIFO
//   drop_cnt  out  8              number of dropped bytes, saturating at 255

module uart_echo_responder #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_rdy,
    output logic [7:0]            tx_byte,
    output logic                  stb,
    input  logic                  tx_rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef UART_ECHO_CRLF_EN
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
`ifdef UART_ECHO_CRLF_EN
        ,
        SEND_LF   = 2'd3
`endif
    } state_t;

    state_t state;
    state_t state_n;

    // ------------------------------------------------------------------
    // Receive edge detection
    // ------------------------------------------------------------------
    logic rx_rdy_q;
    // Cleared by reset and set on the first clock afterwards: a level that is
    // already high when reset lifts must be sampled once before it can count
    // as an edge, otherwise a stale byte would be echoed.
    logic armed;
    logic rise;

    assign rise = rx_rdy & ~rx_rdy_q & armed;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [7:0]            head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // only refused when nothing is leaving.
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_byte;
        end
    end

    // ------------------------------------------------------------------
    // Transmit sequencing
    // ------------------------------------------------------------------
    logic [2:0] wait_cnt;
    logic       load;
    logic [7:0] load_byte;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        load_byte = head;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && tx_rdy) begin
                    load    = 1'b1;
                    pop     = 1'b1;
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never shows busy within eight cycles is
                // assumed to have taken the byte anyway.
                if (!tx_rdy || wait_cnt == 3'd7) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_rdy) begin
`ifdef UART_ECHO_CRLF_EN
                    // tx_byte still holds the byte that just finished.
                    if (tx_byte == CR) begin
                        state_n = SEND_LF;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            SEND_LF: begin
                if (tx_rdy) begin
                    load      = 1'b1;
                    load_byte = LF;
                    state_n   = WAIT_BUSY;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            tx_byte  <= 8'h00;
            stb      <= 1'b0;
        end else begin
            state <= state_n;
            stb   <= load;
            if (load) begin
                tx_byte <= load_byte;
            end
            if (state == WAIT_BUSY) begin
                wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rx_rdy_q <= 1'b0;
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            rx_rdy_q <= rx_rdy;
            armed    <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - self-checking bench for uart_echo_responder

module tb_uart_echo_responder;

    localparam int DL2 = 3;

    logic         clk = 1'b0;
    logic         res_n;
    logic [7:0]   rx_byte;
    logic         rx_rdy;
    logic [7:0]   tx_byte;
    logic         stb;
    logic         tx_rdy;
    logic [DL2:0] level;
    logic         overflow;
    logic [7:0]   drop_cnt;

    logic tx_auto = 1'b0;
    logic tx_hold = 1'b1;
    logic model_rdy = 1'b1;
    int   busy = 0;

    int n_asserts = 0;
    int n_fail = 0;
    int viol = 0;
    logic prev_stb = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign tx_rdy = tx_auto ? model_rdy : tx_hold;

    uart_echo_responder #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .res_n    (res_n),
        .rx_byte  (rx_byte),
        .rx_rdy   (rx_rdy),
        .tx_byte  (tx_byte),
        .stb      (stb),
        .tx_rdy   (tx_rdy),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always @(negedge clk) begin
        if (stb && $urandom_range(0, 3) != 0) begin
            model_rdy = 1'b0;
            busy = $urandom_range(1, 5);
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) model_rdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (stb) begin
            got.push_back(tx_byte);
            if (prev_stb) viol++;
            if (!tx_rdy) viol++;
        end
        prev_stb = stb;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, got.size() >= n, got.size(), n);
    endtask

    task automatic compare(input logic [7:0] exp[$], input string tag);
        chk({tag, "_count"}, got.size() === exp.size(), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk(tag, got[i] === exp[i], got[i], exp[i]);
        end
    endtask

    initial begin
        res_n = 1'b0;
        rx_rdy = 1'b1;
        rx_byte = 8'h99;
        tick(3);
        chk("rst_tx_byte", tx_byte === 8'h00, tx_byte, 8'h00);
        chk("rst_stb", stb === 1'b0, stb, 1'b0);
        chk("rst_level", level === 4'd0, level, 4'd0);
        chk("rst_overflow", overflow === 1'b0, overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt === 8'd0, drop_cnt, 8'd0);

        res_n = 1'b1;
        tick(3);
        chk("edge_at_release", level === 4'd0, level, 4'd0);
        rx_rdy = 1'b0;
        tick(2);

        got.delete();
        rx_byte = 8'h41;
        rx_rdy = 1'b1;
        @(negedge clk);
        chk("single_level_after_write", level === 4'd1, level, 4'd1);
        chk("single_no_early_stb", stb === 1'b0, stb, 1'b0);
        rx_rdy = 1'b0;
        @(negedge clk);
        chk("single_stb", stb === 1'b1, stb, 1'b1);
        chk("single_tx_byte", tx_byte === 8'h41, tx_byte, 8'h41);
        chk("single_level_after_pop", level === 4'd0, level, 4'd0);
        @(negedge clk);
        chk("single_stb_one_cycle", stb === 1'b0, stb, 1'b0);
        tick(12);
        chk("single_overflow", overflow === 1'b0, overflow, 1'b0);
        chk("single_count", got.size() === 1, got.size(), 1);
        chk("single_tx_byte_hold", tx_byte === 8'h41, tx_byte, 8'h41);

        tx_hold = 1'b0;
        got.delete();
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        chk("burst_level", level === 4'd5, level, 4'd5);
        chk("burst_no_stb", got.size() === 0, got.size(), 0);
        tx_auto = 1'b1;
        wait_got(5, 300, "burst_wait");
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        compare(exp_q, "burst_order");
        tick(20);
        chk("burst_drained", level === 4'd0, level, 4'd0);

        tx_auto = 1'b0;
        tx_hold = 1'b0;
        got.delete();
        for (int i = 0; i < 10; i++) send(8'h20 + 8'(i));
        chk("ovf_level", level === 4'd8, level, 4'd8);
        chk("ovf_flag", overflow === 1'b1, overflow, 1'b1);
        chk("ovf_drop_cnt", drop_cnt === 8'd2, drop_cnt, 8'd2);
        rx_byte = 8'h2A;
        rx_rdy = 1'b1;
        tx_hold = 1'b1;
        @(negedge clk);
        chk("pushpop_level", level === 4'd8, level, 4'd8);
        chk("pushpop_drop_cnt", drop_cnt === 8'd2, drop_cnt, 8'd2);
        chk("pushpop_stb", stb === 1'b1, stb, 1'b1);
        chk("pushpop_tx_byte", tx_byte === 8'h20, tx_byte, 8'h20);
        tx_hold = 1'b0;
        rx_rdy = 1'b0;
        tick(2);
        tx_auto = 1'b1;
        wait_got(9, 500, "ovf_wait");
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h20 + 8'(i));
        exp_q.push_back(8'h2A);
        compare(exp_q, "ovf_order");
        tick(20);
        chk("ovf_drained", level === 4'd0, level, 4'd0);

        tx_auto = 1'b0;
        tx_hold = 1'b1;
        got.delete();
        send(8'h51);
        tx_hold = 1'b0;
        send(8'h52);
        send(8'h53);
        send(8'h54);
        chk("midrst_level_before", level === 4'd3, level, 4'd3);
        chk("midrst_tx_byte_before", tx_byte === 8'h51, tx_byte, 8'h51);
        #2;
        res_n = 1'b0;
        #1;
        chk("midrst_stb", stb === 1'b0, stb, 1'b0);
        chk("midrst_level", level === 4'd0, level, 4'd0);
        chk("midrst_tx_byte", tx_byte === 8'h00, tx_byte, 8'h00);
        chk("midrst_overflow", overflow === 1'b0, overflow, 1'b0);
        chk("midrst_drop_cnt", drop_cnt === 8'd0, drop_cnt, 8'd0);
        @(negedge clk);
        res_n = 1'b1;
        tx_hold = 1'b1;
        tick(12);
        chk("midrst_no_stb_after", got.size() === 1, got.size(), 1);
        send(8'h61);
        tick(2);
        chk("midrst_new_count", got.size() === 2, got.size(), 2);
        chk("midrst_new_byte", got[got.size()-1] === 8'h61, got[got.size()-1], 8'h61);
        tick(12);

        tx_auto = 1'b1;
        got.delete();
        exp_q.delete();
        exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h42);
        send(8'h0D);
        send(8'h42);
        wait_got(exp_q.size(), 300, "crlf_wait");
        tick(20);
        compare(exp_q, "crlf_seq");
        chk("crlf_level", level === 4'd0, level, 4'd0);

        for (int b = 0; b < 6; b++) begin
            int n;
            logic [7:0] v;
            got.delete();
            exp_q.delete();
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                v = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
                exp_q.push_back(v);
`ifdef UART_ECHO_CRLF_EN
                if (v == 8'h0D) exp_q.push_back(8'h0A);
`endif
                send(v);
                tick($urandom_range(0, 3));
            end
            wait_got(exp_q.size(), 800, "rand_wait");
            tick(30);
            compare(exp_q, "rand_seq");
            chk("rand_drop_cnt", drop_cnt === 8'd0, drop_cnt, 8'd0);
            chk("rand_level", level === 4'd0, level, 4'd0);
        end

        chk("stb_protocol_violations", viol === 0, viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
